issue_age_arbiter: RTL and testbench

- Per-queue select controller for the issue queue.
- Tracks entry occupancy and relative age (age matrix) for QUEUE_SIZE slots.
- Each cycle, grants up to ISSUE_WIDTH operand-ready entries, oldest first, to the functional-unit issue ports; releases slots on handshake.
- Sits between the issue-queue storage (which supplies slot indices and ready bits) and the FU issue ports (which supply backpressure).

---
 rtl/iq_pkg.sv | 20 ++
 rtl/age_oldest_select.sv | 33 +++
 rtl/issue_age_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_issue_age_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_pkg.sv
// -----------------------------------------------------------------------------
// iq_pkg
// Shared defaults and types for the issue-queue select logic.
//   IQ_QUEUE_SIZE  : default number of queue slots
//   IQ_ALLOC_WIDTH : default allocation ports per cycle
//   IQ_ISSUE_WIDTH : default issue/grant ports per cycle
//   iq_idx_t       : slot index at the default queue size
//   age_row_t      : one row (or column) of the age matrix at the default size
// -----------------------------------------------------------------------------
package iq_pkg;

   localparam int IQ_QUEUE_SIZE  = 8;
   localparam int IQ_ALLOC_WIDTH = 2;
   localparam int IQ_ISSUE_WIDTH = 2;
   localparam int IQ_IDX_W       = $clog2(IQ_QUEUE_SIZE);

   typedef logic [IQ_IDX_W-1:0]      iq_idx_t;
   typedef logic [IQ_QUEUE_SIZE-1:0] age_row_t;

endpackage

// File: rtl/age_oldest_select.sv
// -----------------------------------------------------------------------------
// age_oldest_select
// Combinational oldest-candidate picker over an age matrix.
//   cand   in  N      candidate slots
//   older  in  N x N  older[i][j]=1 : slot i is older than slot j
//   oldest out N      one-hot oldest candidate (all zero when cand is empty)
//   found  out 1      a candidate was picked
// -----------------------------------------------------------------------------
module age_oldest_select #(
   parameter int N = 8
) (
   input  logic [N-1:0]        cand,
   input  logic [N-1:0][N-1:0] older,
   output logic [N-1:0]        oldest,
   output logic                found
);

   // A candidate wins when no other candidate is older than it. Rows of
   // non-candidates may hold stale bits, so every term is masked by cand.
   for (genvar gi = 0; gi < N; gi++) begin : g_slot
      logic [N-1:0] beaten_by;
      always_comb begin
         beaten_by = '0;
         for (int j = 0; j < N; j++) begin
            beaten_by[j] = cand[j] & older[j][gi] & (j != gi);
         end
      end
      assign oldest[gi] = cand[gi] & ~(|beaten_by);
   end

   assign found = |oldest;

endmodule

// File: rtl/issue_age_arbiter.sv
// -----------------------------------------------------------------------------
// issue_age_arbiter
// Per-queue select controller: tracks slot occupancy and relative age, grants
// up to ISSUE_WIDTH operand-ready slots oldest-first, releases on handshake.
//   clk            in  1                    clock, rising edge
//   a_rst_n        in  1                    synchronous active-low reset
//   flush_i        in  1                    drop all entries, suppress grants
//   alloc_valid_i  in  ALLOC_WIDTH          allocate on port a
//   alloc_idx_i    in  ALLOC_WIDTH x IDX_W  slot written by port a
//   entry_ready_i  in  QUEUE_SIZE           operands ready per slot
//   port_ready_i   in  ISSUE_WIDTH          FU port k accepts this cycle
//   grant_valid_o  out ISSUE_WIDTH          port k presents a slot
//   grant_idx_o    out ISSUE_WIDTH x IDX_W  slot presented on port k
//   entry_valid_o  out QUEUE_SIZE           registered occupancy
//   free_count_o   out CNT_W                registered count of empty slots
// Build option: define IQ_ORDER_ISSUE_EN for in-order issue (only the oldest
// valid slot may issue, on port 0 only).
// -----------------------------------------------------------------------------
module issue_age_arbiter
   import iq_pkg::*;
#(
   parameter  int QUEUE_SIZE  = IQ_QUEUE_SIZE,
   parameter  int ALLOC_WIDTH = IQ_ALLOC_WIDTH,
   parameter  int ISSUE_WIDTH = IQ_ISSUE_WIDTH,
   localparam int IDX_W       = $clog2(QUEUE_SIZE),
   localparam int CNT_W       = $clog2(QUEUE_SIZE + 1)
) (
   input  logic                                clk,
   input  logic                                a_rst_n,
   input  logic                                flush_i,
   input  logic [ALLOC_WIDTH-1:0]              alloc_valid_i,
   input  logic [ALLOC_WIDTH-1:0][IDX_W-1:0]   alloc_idx_i,
   input  logic [QUEUE_SIZE-1:0]               entry_ready_i,
   input  logic [ISSUE_WIDTH-1:0]              port_ready_i,
   output logic [ISSUE_WIDTH-1:0]              grant_valid_o,
   output logic [ISSUE_WIDTH-1:0][IDX_W-1:0]   grant_idx_o,
   output logic [QUEUE_SIZE-1:0]               entry_valid_o,
   output logic [CNT_W-1:0]                    free_count_o
);

   logic [QUEUE_SIZE-1:0]                 valid_reg, valid_next;
   logic [QUEUE_SIZE-1:0][QUEUE_SIZE-1:0] age_reg, age_next;
   logic [ISSUE_WIDTH-1:0]                hold_valid_reg, hold_valid_next;
   logic [ISSUE_WIDTH-1:0][IDX_W-1:0]     hold_idx_reg, hold_idx_next;
   logic [CNT_W-1:0]                      free_count_reg, free_count_next;

   logic [ISSUE_WIDTH-1:0][QUEUE_SIZE-1:0] pick;     // one-hot pick per port
   logic [ISSUE_WIDTH-1:0]                 eligible; // port has a fresh slot to offer
   logic [QUEUE_SIZE-1:0]                  release_mask, alloc_mask, survive;

   // ---------------------------------------------------------------- select
`ifdef IQ_ORDER_ISSUE_EN
   // In-order: only the head of the age order may issue, and only if ready.
   logic [QUEUE_SIZE-1:0] head_onehot;
   logic                  head_found;

   age_oldest_select #(.N(QUEUE_SIZE)) u_head (
      .cand   (valid_reg),
      .older  (age_reg),
      .oldest (head_onehot),
      .found  (head_found)
   );

   assign pick[0]     = head_onehot;
   assign eligible[0] = head_found & (|(head_onehot & entry_ready_i));
   for (genvar gi = 1; gi < ISSUE_WIDTH; gi++) begin : g_tied
      assign pick[gi]     = '0;
      assign eligible[gi] = 1'b0;
   end
`else
   // Slots re-presented by a holding port are off limits to every other port.
   logic [QUEUE_SIZE-1:0] held_mask;
   always_comb begin
      held_mask = '0;
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
         if (hold_valid_reg[k]) held_mask[hold_idx_reg[k]] = 1'b1;
      end
   end

   // Selector chain: each stage sees the candidates left by earlier stages.
   // A holding port's stage pick is unused, so it does not remove anything.
   for (genvar gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_sel
      logic [QUEUE_SIZE-1:0] cand, claim;
      logic                  found;
      if (gi == 0) begin : g_first
         assign cand = valid_reg & entry_ready_i & ~held_mask;
      end else begin : g_rest
         assign cand = g_sel[gi-1].cand & ~g_sel[gi-1].claim;
      end
      age_oldest_select #(.N(QUEUE_SIZE)) u_sel (
         .cand   (cand),
         .older  (age_reg),
         .oldest (pick[gi]),
         .found  (found)
      );
      assign claim        = pick[gi] & {QUEUE_SIZE{~hold_valid_reg[gi]}};
      assign eligible[gi] = found;
   end
`endif

   // ---------------------------------------------------------------- grants
   for (genvar gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_grant
      logic [IDX_W-1:0] pick_idx, gidx;
      logic             gv;
      always_comb begin
         pick_idx = '0;
         for (int i = 0; i < QUEUE_SIZE; i++) begin
            if (pick[gi][i]) pick_idx = pick_idx | IDX_W'(i);
         end
      end
      always_comb begin
         gv   = 1'b0;
         gidx = '0;
         if (!flush_i) begin
            if (hold_valid_reg[gi]) begin
               gv   = 1'b1;
               gidx = hold_idx_reg[gi];
            end else if (eligible[gi]) begin
               gv   = 1'b1;
               gidx = pick_idx;
            end
         end
      end
      assign grant_valid_o[gi] = gv;
      assign grant_idx_o[gi]   = gidx;
   end

   // ---------------------------------------------------------- next state
   always_comb begin
      release_mask = '0;
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
         if (grant_valid_o[k] && port_ready_i[k]) release_mask[grant_idx_o[k]] = 1'b1;
      end
      alloc_mask = '0;
      for (int p = 0; p < ALLOC_WIDTH; p++) begin
         if (alloc_valid_i[p]) alloc_mask[alloc_idx_i[p]] = 1'b1;
      end
      survive    = valid_reg & ~release_mask;
      valid_next = survive | alloc_mask;

      // New occupant is younger than every survivor; a released-and-
      // reallocated index is not a survivor, so it ends up youngest.
      age_next = age_reg;
      for (int p = 0; p < ALLOC_WIDTH; p++) begin
         if (alloc_valid_i[p]) begin
            age_next[alloc_idx_i[p]] = '0;
            for (int r = 0; r < QUEUE_SIZE; r++) begin
               age_next[r][alloc_idx_i[p]] = survive[r];
            end
         end
      end
      // Same-cycle allocations: lower port is older.
      for (int p = 0; p < ALLOC_WIDTH; p++) begin
         for (int q = p + 1; q < ALLOC_WIDTH; q++) begin
            if (alloc_valid_i[p] && alloc_valid_i[q]) begin
               age_next[alloc_idx_i[p]][alloc_idx_i[q]] = 1'b1;
               age_next[alloc_idx_i[q]][alloc_idx_i[p]] = 1'b0;
            end
         end
      end

      // Full queue needs no gating here: a legal allocation at full always
      // reuses an index released in the same cycle.
      free_count_next = free_count_reg + CNT_W'($countones(release_mask))
                                       - CNT_W'($countones(alloc_mask));

      for (int k = 0; k < ISSUE_WIDTH; k++) begin
         hold_valid_next[k] = grant_valid_o[k] & ~port_ready_i[k];
         hold_idx_next[k]   = hold_valid_next[k] ? grant_idx_o[k] : '0;
      end

      if (flush_i) begin
         valid_next      = '0;
         age_next        = '0;
         hold_valid_next = '0;
         hold_idx_next   = '0;
         free_count_next = CNT_W'(QUEUE_SIZE);
      end
   end

   always_ff @(posedge clk) begin
      if (!a_rst_n) begin
         valid_reg      <= '0;
         age_reg        <= '0;
         hold_valid_reg <= '0;
         hold_idx_reg   <= '0;
         free_count_reg <= CNT_W'(QUEUE_SIZE);
      end else begin
         valid_reg      <= valid_next;
         age_reg        <= age_next;
         hold_valid_reg <= hold_valid_next;
         hold_idx_reg   <= hold_idx_next;
         free_count_reg <= free_count_next;
      end
   end

   // Illegal allocation patterns (counting same-cycle releases as free).
   always @(posedge clk) begin
      if (a_rst_n && !flush_i) begin
         for (int p = 0; p < ALLOC_WIDTH; p++) begin
            if (alloc_valid_i[p]) begin
               assert (!(valid_reg[alloc_idx_i[p]] && !release_mask[alloc_idx_i[p]]))
                  else $error("alloc of occupied slot %0d", alloc_idx_i[p]);
               for (int q = p + 1; q < ALLOC_WIDTH; q++) begin
                  assert (!(alloc_valid_i[q] && alloc_idx_i[q] == alloc_idx_i[p]))
                     else $error("duplicate alloc index %0d", alloc_idx_i[p]);
               end
            end
         end
         assert ($countones(alloc_valid_i) <= int'(free_count_reg) + $countones(release_mask))
            else $error("alloc exceeds free slots");
      end
   end

   assign entry_valid_o = valid_reg;
   assign free_count_o  = free_count_reg;

endmodule

// File: tb/tb_issue_age_arbiter.sv
// -----------------------------------------------------------------------------
// tb_issue_age_arbiter
// Directed scenarios followed by random traffic. The reference keeps the
// occupied slots as a queue in age order (front = oldest) and hands out grants
// by walking that queue.
// -----------------------------------------------------------------------------
module tb_issue_age_arbiter;
   import iq_pkg::*;

   localparam int QS = IQ_QUEUE_SIZE;
   localparam int AW = IQ_ALLOC_WIDTH;
   localparam int IW = IQ_ISSUE_WIDTH;
   localparam int XW = $clog2(QS);
   localparam int CW = $clog2(QS + 1);

   logic                   clk = 1'b0;
   logic                   a_rst_n = 1'b0;
   logic                   flush_i = 1'b0;
   logic [AW-1:0]          alloc_valid_i = '0;
   logic [AW-1:0][XW-1:0]  alloc_idx_i = '0;
   logic [QS-1:0]          entry_ready_i = '0;
   logic [IW-1:0]          port_ready_i = '0;
   logic [IW-1:0]          grant_valid_o;
   logic [IW-1:0][XW-1:0]  grant_idx_o;
   logic [QS-1:0]          entry_valid_o;
   logic [CW-1:0]          free_count_o;

   issue_age_arbiter dut (
      .clk           (clk),
      .a_rst_n       (a_rst_n),
      .flush_i       (flush_i),
      .alloc_valid_i (alloc_valid_i),
      .alloc_idx_i   (alloc_idx_i),
      .entry_ready_i (entry_ready_i),
      .port_ready_i  (port_ready_i),
      .grant_valid_o (grant_valid_o),
      .grant_idx_o   (grant_idx_o),
      .entry_valid_o (entry_valid_o),
      .free_count_o  (free_count_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference state
   int age_q[$];
   bit hv[IW];
   int hidx[IW];
   bit egv[IW];
   int egi[IW];

   // Snapshot of the DUT at the last sample point
   logic [IW-1:0]         snap_gv;
   logic [IW-1:0][XW-1:0] snap_gi;
   logic [QS-1:0]         snap_valid;
   logic [CW-1:0]         snap_free;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_grants();
      bit claimed[QS];
      for (int k = 0; k < IW; k++) begin
         egv[k] = 1'b0;
         egi[k] = 0;
      end
      if (flush_i) return;
      for (int s = 0; s < QS; s++) claimed[s] = 1'b0;
      for (int k = 0; k < IW; k++) if (hv[k]) claimed[hidx[k]] = 1'b1;
`ifdef IQ_ORDER_ISSUE_EN
      if (hv[0]) begin
         egv[0] = 1'b1;
         egi[0] = hidx[0];
      end else if (age_q.size() > 0 && entry_ready_i[age_q[0]] === 1'b1) begin
         egv[0] = 1'b1;
         egi[0] = age_q[0];
      end
`else
      for (int k = 0; k < IW; k++) begin
         if (hv[k]) begin
            egv[k] = 1'b1;
            egi[k] = hidx[k];
         end else begin
            for (int n = 0; n < age_q.size() && !egv[k]; n++) begin
               if (!claimed[age_q[n]] && entry_ready_i[age_q[n]] === 1'b1) begin
                  egv[k] = 1'b1;
                  egi[k] = age_q[n];
                  claimed[age_q[n]] = 1'b1;
               end
            end
         end
      end
`endif
   endfunction

   function automatic void model_update();
      if (!a_rst_n || flush_i) begin
         age_q.delete();
         for (int k = 0; k < IW; k++) begin
            hv[k]   = 1'b0;
            hidx[k] = 0;
         end
         return;
      end
      for (int k = 0; k < IW; k++) begin
         if (egv[k] && port_ready_i[k]) begin
            for (int n = 0; n < age_q.size(); n++) begin
               if (age_q[n] == egi[k]) begin
                  age_q.delete(n);
                  break;
               end
            end
         end
      end
      for (int k = 0; k < IW; k++) begin
         hv[k]   = egv[k] && !port_ready_i[k];
         hidx[k] = hv[k] ? egi[k] : 0;
      end
      for (int p = 0; p < AW; p++) begin
         if (alloc_valid_i[p]) age_q.push_back(int'(alloc_idx_i[p]));
      end
   endfunction

   function automatic bit in_queue(input int s);
      foreach (age_q[n]) if (age_q[n] == s) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drive(input logic [1:0] av, input int a0, input int a1,
                        input logic [7:0] er, input logic [1:0] pr, input logic fl);
      alloc_valid_i  = av;
      alloc_idx_i[0] = XW'(a0);
      alloc_idx_i[1] = XW'(a1);
      entry_ready_i  = er;
      port_ready_i   = pr;
      flush_i        = fl;
   endtask

   // One clock: sample and compare on the falling edge, then advance the model.
   task automatic step();
      logic [IW-1:0]         exp_gv;
      logic [IW-1:0][XW-1:0] exp_gi;
      logic [QS-1:0]         exp_valid;
      @(negedge clk);
      model_grants();
      exp_gv = '0;
      exp_gi = '0;
      for (int k = 0; k < IW; k++) begin
         exp_gv[k] = egv[k];
         exp_gi[k] = XW'(egi[k]);
      end
      exp_valid = '0;
      foreach (age_q[n]) exp_valid[age_q[n]] = 1'b1;
      snap_gv    = grant_valid_o;
      snap_gi    = grant_idx_o;
      snap_valid = entry_valid_o;
      snap_free  = free_count_o;
      check("grant_valid", 32'(snap_gv), 32'(exp_gv));
      check("grant_idx", 32'(snap_gi), 32'(exp_gi));
      check("entry_valid", 32'(snap_valid), 32'(exp_valid));
      check("free_count", 32'(snap_free), 32'(QS - age_q.size()));
      $display("cyc %0d rst_n=%0b flush=%0b alloc=%b(%0d,%0d) ready=%h pready=%b grant=%b idx=%0d,%0d valid=%h free=%0d",
               cyc, a_rst_n, flush_i, alloc_valid_i, alloc_idx_i[0], alloc_idx_i[1], entry_ready_i,
               port_ready_i, snap_gv, snap_gi[0], snap_gi[1], snap_valid, snap_free);
      @(posedge clk);
      model_update();
      cyc++;
      #1;
   endtask

   initial begin
      int free_l[$];
      int pos;

      // Reset, then idle
      drive(2'b00, 0, 0, 8'h00, 2'b00, 1'b0);
      a_rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      a_rst_n = 1'b1;
      repeat (10) step();
      check("reset_free", 32'(snap_free), 32'd8);
      check("reset_valid", 32'(snap_valid), 32'd0);

`ifndef IQ_ORDER_ISSUE_EN
      // Oldest-first across ports, port order breaks same-cycle ties
      drive(2'b11, 5, 2, 8'h00, 2'b11, 1'b0); step();
      drive(2'b01, 7, 0, 8'h00, 2'b11, 1'b0); step();
      drive(2'b00, 0, 0, 8'hFF, 2'b11, 1'b0); step();
      check("tp2_gv", 32'(snap_gv), 32'b11);
      check("tp2_p0", 32'(snap_gi[0]), 32'd5);
      check("tp2_p1", 32'(snap_gi[1]), 32'd2);
      step();
      check("tp2_gv2", 32'(snap_gv), 32'b01);
      check("tp2_p0b", 32'(snap_gi[0]), 32'd7);
      drive(2'b00, 0, 0, 8'h00, 2'b11, 1'b0); step();
      check("tp2_free", 32'(snap_free), 32'd8);

      // Hold: port 0 keeps slot 3 even when an older slot becomes ready
      drive(2'b01, 1, 0, 8'h00, 2'b11, 1'b0); step();
      drive(2'b01, 3, 0, 8'h00, 2'b11, 1'b0); step();
      drive(2'b00, 0, 0, 8'h08, 2'b10, 1'b0); step();
      check("hold_p0", 32'(snap_gi[0]), 32'd3);
      drive(2'b00, 0, 0, 8'h02, 2'b11, 1'b0); step();
      check("hold_gv", 32'(snap_gv), 32'b11);
      check("hold_p0b", 32'(snap_gi[0]), 32'd3);
      check("hold_p1", 32'(snap_gi[1]), 32'd1);
      drive(2'b00, 0, 0, 8'h00, 2'b00, 1'b0); step();

      // Fill, then release and reallocate slot 4 in one cycle
      for (int i = 0; i < 4; i++) begin
         drive(2'b11, 2 * i, 2 * i + 1, 8'h00, 2'b00, 1'b0); step();
      end
      drive(2'b00, 0, 0, 8'h00, 2'b00, 1'b0); step();
      check("full_free", 32'(snap_free), 32'd0);
      drive(2'b01, 4, 0, 8'h10, 2'b01, 1'b0); step();
      check("realloc_p0", 32'(snap_gi[0]), 32'd4);
      drive(2'b00, 0, 0, 8'hFF, 2'b11, 1'b0); step();
      check("realloc_v4", 32'(snap_valid[4]), 32'd1);
      check("realloc_free", 32'(snap_free), 32'd0);
      step(); step(); step();
      check("realloc_last", 32'(snap_gi[1]), 32'd4);
      drive(2'b00, 0, 0, 8'h00, 2'b00, 1'b0); step();

      // Flush with six occupied slots and two active holds
      for (int i = 0; i < 3; i++) begin
         drive(2'b11, 2 * i, 2 * i + 1, 8'h00, 2'b00, 1'b0); step();
      end
      drive(2'b00, 0, 0, 8'h03, 2'b00, 1'b0); step();
      drive(2'b01, 6, 0, 8'hFF, 2'b11, 1'b1); step();
      check("flush_gv", 32'(snap_gv), 32'b00);
      drive(2'b00, 0, 0, 8'hFF, 2'b11, 1'b0); step();
      check("flush_valid", 32'(snap_valid), 32'd0);
      check("flush_free", 32'(snap_free), 32'd8);
`else
      // In-order: head slot 6 blocks a ready younger slot
      drive(2'b01, 6, 0, 8'h00, 2'b11, 1'b0); step();
      drive(2'b01, 0, 0, 8'h00, 2'b11, 1'b0); step();
      drive(2'b00, 0, 0, 8'h01, 2'b11, 1'b0); step();
      check("ino_block", 32'(snap_gv), 32'b00);
      drive(2'b00, 0, 0, 8'h41, 2'b11, 1'b0); step();
      check("ino_gv", 32'(snap_gv), 32'b01);
      check("ino_p0", 32'(snap_gi[0]), 32'd6);
      step();
      check("ino_next", 32'(snap_gi[0]), 32'd0);
      drive(2'b00, 0, 0, 8'h00, 2'b00, 1'b0); step();
`endif

      // Random legal traffic
      for (int t = 0; t < 500; t++) begin
         free_l.delete();
         for (int s = 0; s < QS; s++) if (!in_queue(s)) free_l.push_back(s);
         alloc_valid_i = '0;
         alloc_idx_i   = '0;
         for (int p = 0; p < AW; p++) begin
            if (free_l.size() > 0 && $urandom_range(0, 99) < 55) begin
               pos = $urandom_range(0, free_l.size() - 1);
               alloc_valid_i[p] = 1'b1;
               alloc_idx_i[p]   = XW'(free_l[pos]);
               free_l.delete(pos);
            end
         end
         entry_ready_i = QS'($urandom);
         port_ready_i  = IW'($urandom_range(0, 3));
         flush_i       = ($urandom_range(0, 39) == 0);
         step();
      end

      // Reset with occupancy present, asserted together with flush
      drive(2'b11, 0, 0, 8'h00, 2'b00, 1'b0);
      alloc_valid_i = '0;
      for (int s = 0; s < QS && alloc_valid_i != 2'b11; s++) begin
         if (!in_queue(s)) begin
            if (!alloc_valid_i[0]) begin
               alloc_valid_i[0] = 1'b1;
               alloc_idx_i[0]   = XW'(s);
            end else begin
               alloc_valid_i[1] = 1'b1;
               alloc_idx_i[1]   = XW'(s);
            end
         end
      end
      step();
      drive(2'b00, 0, 0, 8'hFF, 2'b00, 1'b1);
      a_rst_n = 1'b0;
      step();
      a_rst_n = 1'b1;
      drive(2'b00, 0, 0, 8'hFF, 2'b11, 1'b0);
      step();
      check("rst_free", 32'(snap_free), 32'd8);
      check("rst_gv", 32'(snap_gv), 32'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
